// File: rtl/updi_double_break.sv
// UPDI double-break generator: holds the UPDI line low twice, with high gaps,
// to reset the target's UPDI PHY. RX is masked so break echoes are not decoded.
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | line follows UART TX, waiting for start
// WAIT_TX | start accepted, letting an in-flight UART frame finish
// BREAK1  | first break, line forced low
// GAP     | line forced high between the breaks
// BREAK2  | second break, line forced low
// RECOVER | line forced high before handing back to the UART
module updi_double_break #(
  parameter int BREAK_CYCLES    = 295200,
  parameter int GAP_CYCLES      = 12000,
  parameter int RECOVERY_CYCLES = 12000,
  parameter int CNT_BITS = $clog2((BREAK_CYCLES > GAP_CYCLES ?
                                   (BREAK_CYCLES > RECOVERY_CYCLES ? BREAK_CYCLES : RECOVERY_CYCLES) :
                                   (GAP_CYCLES > RECOVERY_CYCLES ? GAP_CYCLES : RECOVERY_CYCLES))) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  input  logic uart_tx_in,
  input  logic uart_tx_idle,
  output logic updi_tx_out,
  output logic rx_mask
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_TX = 3'd1,
    BREAK1  = 3'd2,
    GAP     = 3'd3,
    BREAK2  = 3'd4,
    RECOVER = 3'd5
  } state_t;

  localparam logic [CNT_BITS-1:0] BREAK_LOAD    = CNT_BITS'(BREAK_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] GAP_LOAD      = CNT_BITS'(GAP_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] RECOVERY_LOAD = CNT_BITS'(RECOVERY_CYCLES - 1);

  state_t              state;
  logic [CNT_BITS-1:0] cnt;
  logic                cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (abort && state != IDLE) begin
      // abort beats a phase expiring in the same cycle
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (uart_tx_idle) begin
            state <= BREAK1;
            cnt   <= BREAK_LOAD;
          end
        end
        BREAK1: begin
          if (cnt_zero) begin
            state <= GAP;
            cnt   <= GAP_LOAD;
          end else begin
            cnt <= cnt - CNT_BITS'(1);
          end
        end
        GAP: begin
          if (cnt_zero) begin
            state <= BREAK2;
            cnt   <= BREAK_LOAD;
          end else begin
            cnt <= cnt - CNT_BITS'(1);
          end
        end
        BREAK2: begin
          if (cnt_zero) begin
            state <= RECOVER;
            cnt   <= RECOVERY_LOAD;
          end else begin
            cnt <= cnt - CNT_BITS'(1);
          end
        end
        RECOVER: begin
          if (cnt_zero) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_BITS'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign rx_mask = busy;

  // only the registered state selects the override, so transitions cannot glitch
  always_comb begin
    updi_tx_out = uart_tx_in;
    case (state)
      BREAK1, BREAK2: updi_tx_out = 1'b0;
      GAP, RECOVER:   updi_tx_out = 1'b1;
      default:        updi_tx_out = uart_tx_in;
    endcase
  end

endmodule

// File: tb/tb_updi_double_break.sv
// Bench for updi_double_break: cycle-vector table fed through a scoreboard,
// plus a hand-written run of a single-cycle-phase instance.
module tb_updi_double_break;

  localparam int B = 10;
  localparam int G = 4;
  localparam int R = 6;

  logic clk = 1'b0;
  logic rst, start, abort, uart_tx_in, uart_tx_idle, start_min;
  logic busy, done, updi_tx_out, rx_mask;
  logic busy_min, done_min, tx_min, rx_mask_min;

  always #5 clk = ~clk;

  updi_double_break #(.BREAK_CYCLES(B), .GAP_CYCLES(G), .RECOVERY_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .uart_tx_in(uart_tx_in), .uart_tx_idle(uart_tx_idle),
    .updi_tx_out(updi_tx_out), .rx_mask(rx_mask)
  );

  updi_double_break #(.BREAK_CYCLES(1), .GAP_CYCLES(1), .RECOVERY_CYCLES(1)) dut_min (
    .clk(clk), .rst(rst), .start(start_min), .abort(abort), .busy(busy_min), .done(done_min),
    .uart_tx_in(uart_tx_in), .uart_tx_idle(uart_tx_idle),
    .updi_tx_out(tx_min), .rx_mask(rx_mask_min)
  );

  // mode: 0 = line passes uart_tx_in, 1 = forced high, 2 = forced low
  typedef struct packed {
    logic       start;
    logic       abort;
    logic       rst;
    logic       idle;
    logic       busy;
    logic       done;
    logic [1:0] mode;
  } vec_t;

  typedef struct {
    int   id;
    int   cyc;
    logic busy;
    logic done;
    logic tx;
  } exp_t;

  vec_t  vq[$];
  int    vid[$];
  int    vcyc[$];
  exp_t  sb[$];
  string names[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string nm, input int cyc, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, req);
    end
  endtask

  // expected {busy, done, mode} at t cycles after the first low cycle
  function automatic logic [3:0] phase(input int t);
    if (t < -1)               return 4'b0000;
    if (t == -1)              return 4'b1000;
    if (t < B)                return 4'b1010;
    if (t < B + G)            return 4'b1001;
    if (t < 2*B + G)          return 4'b1010;
    if (t < 2*B + G + R)      return 4'b1001;
    if (t == 2*B + G + R)     return 4'b0100;
    return 4'b0000;
  endfunction

  task automatic add(input int id, input int cyc, input logic st, input logic ab,
                     input logic rs, input logic idl, input logic [3:0] p);
    vec_t v;
    v.start = st; v.abort = ab; v.rst = rs; v.idle = idl;
    v.busy = p[3]; v.done = p[2]; v.mode = p[1:0];
    vq.push_back(v);
    vid.push_back(id);
    vcyc.push_back(cyc);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({names[e.id], "/busy"},    e.cyc, busy,        e.busy);
      check({names[e.id], "/rx_mask"}, e.cyc, rx_mask,     e.busy);
      check({names[e.id], "/done"},    e.cyc, done,        e.done);
      check({names[e.id], "/tx"},      e.cyc, updi_tx_out, e.tx);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] p;
    logic [3:0] dmin [8];
    int id;

    rst = 1'b1; start = 1'b0; abort = 1'b0; start_min = 1'b0;
    uart_tx_idle = 1'b1; uart_tx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    id = 0; names.push_back("reset");
    for (int c = 0; c < 3; c++) add(id, c, 0, 0, 0, 1, 4'b0000);

    id = 1; names.push_back("normal");
    for (int c = 0; c <= 34; c++) add(id, c, c == 0, 0, 0, 1, phase(c - 2));

    id = 2; names.push_back("tx_busy");
    for (int c = 0; c <= 41; c++) begin
      p = (c >= 1 && c <= 8) ? 4'b1000 : phase(c - 9);
      add(id, c, c == 0, 0, 0, c >= 8, p);
    end

    id = 3; names.push_back("abort_gap");
    for (int c = 0; c <= 40; c++)
      add(id, c, c == 0, c == 13, 0, 1, (c <= 13) ? phase(c - 2) : 4'b0000);

    id = 4; names.push_back("abort_expiry");
    for (int c = 0; c <= 20; c++)
      add(id, c, c == 0, c == 11, 0, 1, (c <= 11) ? phase(c - 2) : 4'b0000);

    id = 5; names.push_back("abort_start_idle");
    for (int c = 0; c <= 7; c++)
      add(id, c, c == 0, c == 0 || c == 4, 0, 1, (c <= 4) ? phase(c - 2) : 4'b0000);

    id = 6; names.push_back("start_busy");
    for (int c = 0; c <= 66; c++) begin
      if (c < 32)       p = phase(c - 2);
      else if (c == 32) p = 4'b0100;
      else              p = phase(c - 34);
      add(id, c, c == 0 || c == 5 || c == 28 || c == 32, 0, 0, 1, p);
    end

    id = 7; names.push_back("reset_break2");
    for (int c = 0; c <= 22; c++)
      add(id, c, c == 0, 0, c == 20, 1, (c <= 20) ? phase(c - 2) : 4'b0000);

    id = 8; names.push_back("after_reset");
    for (int c = 0; c <= 34; c++) add(id, c, c == 0, 0, 0, 1, phase(c - 2));

    while (vq.size() > 0) begin
      vec_t v;
      exp_t e;
      v = vq.pop_front();
      e.id = vid.pop_front();
      e.cyc = vcyc.pop_front();
      @(posedge clk);
      #1;
      start = v.start; abort = v.abort; rst = v.rst; uart_tx_idle = v.idle;
      uart_tx_in = 1'($urandom_range(0, 1));
      e.busy = v.busy;
      e.done = v.done;
      e.tx = (v.mode == 2'd0) ? uart_tx_in : (v.mode == 2'd1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0; rst = 1'b0; uart_tx_idle = 1'b1;
    @(negedge clk);

    // all-ones instance: low 1, high 1, low 1, high 1, done at cycle 6
    dmin = '{4'b0000, 4'b1000, 4'b1010, 4'b1001, 4'b1010, 4'b1001, 4'b0100, 4'b0000};
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      start_min = (c == 0);
      uart_tx_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("degenerate/busy",    c, busy_min,    dmin[c][3]);
      check("degenerate/rx_mask", c, rx_mask_min, dmin[c][3]);
      check("degenerate/done",    c, done_min,    dmin[c][2]);
      check("degenerate/tx",      c, tx_min,
            (dmin[c][1:0] == 2'd0) ? uart_tx_in : (dmin[c][1:0] == 2'd1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
